// File: rtl/adc_hyst_comp.sv
// rtl/adc_hyst_comp.sv - hysteresis ADC comparator with debounce, edge strobes and period meter
//
// Purpose:
//   Compares the registered ADC sample stream against an upper and a lower
//   threshold with hysteresis. A level change is accepted only after DEBOUNCE
//   consecutive qualifying samples. The block emits the comparator level, one
//   cycle rise/fall strobes and the rise-to-rise period in clock cycles.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   swipt_alive  in   link enable; 0 forces the OFF state
//   adc          in   unsigned ADC sample, valid every cycle
//   th_hi        in   upper threshold, unsigned
//   th_lo        in   lower threshold, unsigned (clamped to th_hi)
//   comp         out  registered comparator level
//   rise         out  one-cycle strobe with comp going 0 -> 1 (LOW<->HIGH only)
//   fall         out  one-cycle strobe with comp going 1 -> 0 (LOW<->HIGH only)
//   period       out  cycles between the last two rise strobes
//   period_valid out  one-cycle strobe when period updates

module adc_hyst_comp #(
  parameter int unsigned WIDTH    = 12,
  parameter int unsigned DEBOUNCE = 4,
  parameter int unsigned INVERT   = 1,
  parameter int unsigned PERIOD_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                swipt_alive,
  input  logic [WIDTH-1:0]    adc,
  input  logic [WIDTH-1:0]    th_hi,
  input  logic [WIDTH-1:0]    th_lo,
  output logic                comp,
  output logic                rise,
  output logic                fall,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_t;

  // DEBOUNCE is at most 255, so an 8-bit run counter always suffices.
  localparam int unsigned   DCNT_W   = 8;
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE - 1);

  // Comparator level driven in each active state.
  localparam logic COMP_LOW  = (INVERT != 0);
  localparam logic COMP_HIGH = ~COMP_LOW;

  localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;

  // Registered state
  logic [WIDTH-1:0]    adc_q, adc_d;
  state_t              state_q, state_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
  logic                comp_q, comp_d;
  logic                rise_q, rise_d;
  logic                fall_q, fall_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic                first_seen_q, first_seen_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;

  // Classification of the registered sample
  logic [WIDTH-1:0] lo_eff;
  logic             above;
  logic             below;
  logic             qualify;
  logic             flip;
  logic             new_comp;

  // An inverted threshold pair must not open a window where a sample is
  // both above and below; clamping the low side to th_hi keeps it consistent.
  assign lo_eff = (th_lo < th_hi) ? th_lo : th_hi;
  assign above  = (adc_q > th_hi);
  assign below  = (adc_q < lo_eff);

  always_comb begin
    adc_d          = adc;
    state_d        = state_q;
    dcnt_d         = dcnt_q;
    comp_d         = comp_q;
    rise_d         = 1'b0;
    fall_d         = 1'b0;
    pcnt_d         = pcnt_q;
    first_seen_d   = first_seen_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    qualify        = 1'b0;
    flip           = 1'b0;
    new_comp       = comp_q;

    if (!swipt_alive) begin
      // Link lost: drop everything except the last measured period.
      state_d      = ST_OFF;
      dcnt_d       = '0;
      comp_d       = 1'b0;
      pcnt_d       = '0;
      first_seen_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_LOW, ST_HIGH: begin
          // LOW waits for samples above th_hi, HIGH for samples below lo_eff;
          // anything else (including the hysteresis band) breaks the run.
          qualify = (state_q == ST_LOW) ? above : below;
          if (qualify) begin
            if (dcnt_q == DEB_LAST) begin
              flip   = 1'b1;
              dcnt_d = '0;
            end else begin
              dcnt_d = dcnt_q + 1'b1;
            end
          end else begin
            dcnt_d = '0;
          end

          if (flip) begin
            state_d  = (state_q == ST_LOW) ? ST_HIGH : ST_LOW;
            new_comp = (state_q == ST_LOW) ? COMP_HIGH : COMP_LOW;
            comp_d   = new_comp;
            rise_d   = new_comp;
            fall_d   = ~new_comp;
          end

          // Period meter: the first rise after OFF only arms the meter.
          if (rise_d) begin
            if (first_seen_q) begin
              period_d       = (pcnt_q == PCNT_MAX) ? PCNT_MAX : pcnt_q + 1'b1;
              period_valid_d = 1'b1;
            end
            first_seen_d = 1'b1;
            pcnt_d       = '0;
          end else if (pcnt_q != PCNT_MAX) begin
            pcnt_d = pcnt_q + 1'b1;
          end
        end

        default: begin
          // OFF (or an unused encoding): enter LOW with a clean debounce run.
          state_d      = ST_LOW;
          dcnt_d       = '0;
          comp_d       = COMP_LOW;
          pcnt_d       = '0;
          first_seen_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_q          <= '0;
      state_q        <= ST_OFF;
      dcnt_q         <= '0;
      comp_q         <= 1'b0;
      rise_q         <= 1'b0;
      fall_q         <= 1'b0;
      pcnt_q         <= '0;
      first_seen_q   <= 1'b0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      adc_q          <= adc_d;
      state_q        <= state_d;
      dcnt_q         <= dcnt_d;
      comp_q         <= comp_d;
      rise_q         <= rise_d;
      fall_q         <= fall_d;
      pcnt_q         <= pcnt_d;
      first_seen_q   <= first_seen_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign comp         = comp_q;
  assign rise         = rise_q;
  assign fall         = fall_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;

endmodule

// File: tb/tb_adc_hyst_comp.sv
// tb/tb_adc_hyst_comp.sv - self-checking bench for adc_hyst_comp (three parameter sets)

module tb_adc_hyst_comp;

  logic        clk = 1'b0;
  logic        rst;
  logic        alive;
  logic [11:0] adc;
  logic [11:0] th_hi;
  logic [11:0] th_lo;

  logic        a_comp, a_rise, a_fall, a_pv;
  logic [15:0] a_period;
  logic        b_comp, b_rise, b_fall, b_pv;
  logic [15:0] b_period;
  logic        c_comp, c_rise, c_fall, c_pv;
  logic [5:0]  c_period;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // A: legacy polarity, debounce 4
  adc_hyst_comp #(.WIDTH(12), .DEBOUNCE(4), .INVERT(1), .PERIOD_W(16)) u_a (
    .clk(clk), .rst(rst), .swipt_alive(alive), .adc(adc), .th_hi(th_hi), .th_lo(th_lo),
    .comp(a_comp), .rise(a_rise), .fall(a_fall), .period(a_period), .period_valid(a_pv));

  // B: normal polarity, debounce 4
  adc_hyst_comp #(.WIDTH(12), .DEBOUNCE(4), .INVERT(0), .PERIOD_W(16)) u_b (
    .clk(clk), .rst(rst), .swipt_alive(alive), .adc(adc), .th_hi(th_hi), .th_lo(th_lo),
    .comp(b_comp), .rise(b_rise), .fall(b_fall), .period(b_period), .period_valid(b_pv));

  // C: normal polarity, debounce 1, narrow period counter (saturates at 63)
  adc_hyst_comp #(.WIDTH(12), .DEBOUNCE(1), .INVERT(0), .PERIOD_W(6)) u_c (
    .clk(clk), .rst(rst), .swipt_alive(alive), .adc(adc), .th_hi(th_hi), .th_lo(th_lo),
    .comp(c_comp), .rise(c_rise), .fall(c_fall), .period(c_period), .period_valid(c_pv));

  // Reference model: mode 0=OFF 1=LOW 2=HIGH, run = qualifying samples seen in a row
  int m_inv  [3] = '{1, 0, 0};
  int m_deb  [3] = '{4, 4, 1};
  int m_pmax [3] = '{65535, 65535, 63};
  int m_mode [3];
  int m_run  [3];
  int m_pcnt [3];
  int m_period [3];
  int m_comp [3];
  int m_rise [3];
  int m_fall [3];
  int m_pv   [3];
  int m_first[3];
  int m_adcq;

  function automatic int min_i(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  task automatic model_step();
    int lo;
    int qual;
    int flipped;
    for (int i = 0; i < 3; i++) begin
      if (rst || !alive) begin
        m_mode[i] = 0; m_run[i] = 0; m_comp[i] = 0;
        m_rise[i] = 0; m_fall[i] = 0; m_pv[i] = 0;
        m_pcnt[i] = 0; m_first[i] = 0;
        if (rst) m_period[i] = 0;
      end else if (m_mode[i] == 0) begin
        m_mode[i] = 1; m_run[i] = 0; m_comp[i] = m_inv[i];
        m_rise[i] = 0; m_fall[i] = 0; m_pv[i] = 0;
        m_pcnt[i] = 0; m_first[i] = 0;
      end else begin
        lo = min_i(int'(th_lo), int'(th_hi));
        qual = (m_mode[i] == 1) ? int'(m_adcq > int'(th_hi)) : int'(m_adcq < lo);
        flipped = 0;
        if (qual != 0) begin
          m_run[i]++;
          if (m_run[i] >= m_deb[i]) begin
            m_mode[i] = 3 - m_mode[i];
            m_run[i] = 0;
            flipped = 1;
          end
        end else begin
          m_run[i] = 0;
        end
        m_comp[i] = (m_mode[i] == 2) ? 1 - m_inv[i] : m_inv[i];
        m_rise[i] = flipped & m_comp[i];
        m_fall[i] = flipped & (1 - m_comp[i]);
        m_pv[i] = 0;
        if (m_rise[i] != 0) begin
          if (m_first[i] != 0) begin
            m_period[i] = min_i(m_pcnt[i] + 1, m_pmax[i]);
            m_pv[i] = 1;
          end
          m_first[i] = 1;
          m_pcnt[i] = 0;
        end else begin
          m_pcnt[i] = min_i(m_pcnt[i] + 1, m_pmax[i]);
        end
      end
    end
    m_adcq = rst ? 0 : int'(adc);
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("a_comp",   int'(a_comp),   m_comp[0]);
    check("a_rise",   int'(a_rise),   m_rise[0]);
    check("a_fall",   int'(a_fall),   m_fall[0]);
    check("a_pv",     int'(a_pv),     m_pv[0]);
    check("a_period", int'(a_period), m_period[0]);
    check("b_comp",   int'(b_comp),   m_comp[1]);
    check("b_rise",   int'(b_rise),   m_rise[1]);
    check("b_fall",   int'(b_fall),   m_fall[1]);
    check("b_pv",     int'(b_pv),     m_pv[1]);
    check("b_period", int'(b_period), m_period[1]);
    check("c_comp",   int'(c_comp),   m_comp[2]);
    check("c_rise",   int'(c_rise),   m_rise[2]);
    check("c_fall",   int'(c_fall),   m_fall[2]);
    check("c_pv",     int'(c_pv),     m_pv[2]);
    check("c_period", int'(c_period), m_period[2]);
    check("a_rf_excl", int'(a_rise & a_fall), 0);
    check("b_rf_excl", int'(b_rise & b_fall), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic hold(input logic [11:0] v, input int n);
    adc = v;
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    int run_len;
    int r;
    for (int i = 0; i < 3; i++) begin
      m_mode[i] = 0; m_run[i] = 0; m_pcnt[i] = 0; m_period[i] = 0;
      m_comp[i] = 0; m_rise[i] = 0; m_fall[i] = 0; m_pv[i] = 0; m_first[i] = 0;
    end
    m_adcq = 0;
    rst = 1'b1; alive = 1'b1; adc = 12'h700; th_hi = 12'h810; th_lo = 12'h7F0;

    // Reset state
    hold(12'h700, 3);
    check("rst_comp_a", int'(a_comp), 0);
    check("rst_period_a", int'(a_period), 0);

    // 1: release reset, legacy polarity gives comp=1 in LOW
    rst = 1'b0;
    hold(12'h700, 3);
    check("low_comp_a", int'(a_comp), 1);

    // 2: step above th_hi
    hold(12'h900, 8);
    check("high_comp_a", int'(a_comp), 0);

    // 3: glitch through the band restarts the debounce run
    hold(12'h700, 8);
    hold(12'h900, 3);
    hold(12'h800, 1);
    hold(12'h900, 6);

    // 4: square wave, 100-cycle period, meter rearmed by a link drop
    alive = 1'b0;
    tick();
    alive = 1'b1;
    for (int p = 0; p < 5; p++) begin
      adc = 12'h700;
      for (int k = 0; k < 50; k++) begin
        tick();
        if (b_pv) check("b_sq_period", int'(b_period), 100);
      end
      adc = 12'h900;
      for (int k = 0; k < 50; k++) begin
        tick();
        if (b_pv) check("b_sq_period", int'(b_period), 100);
      end
    end

    // 5: drop the link mid-debounce, then re-enable
    hold(12'h700, 10);
    hold(12'h900, 3);
    alive = 1'b0;
    tick();
    check("off_comp_a", int'(a_comp), 0);
    check("off_fall_a", int'(a_fall), 0);
    alive = 1'b1;
    hold(12'h900, 8);

    // 6: inverted threshold pair clamps lo_eff to th_hi
    th_lo = 12'h900; th_hi = 12'h810;
    hold(12'h900, 8);
    hold(12'h810, 8);
    hold(12'h80F, 8);

    // Randomized phase around the thresholds
    for (int n = 0; n < 3000; n += run_len) begin
      run_len = $urandom_range(1, 6);
      r = $urandom_range(0, 99);
      if (r < 85) adc = 12'($urandom_range(12'h7D0, 12'h840));
      else        adc = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 40) == 0) begin
        th_hi = 12'($urandom_range(12'h7F0, 12'h820));
        th_lo = 12'($urandom_range(12'h7E0, 12'h830));
      end
      alive = ($urandom_range(0, 150) != 0);
      rst   = ($urandom_range(0, 400) == 0);
      for (int k = 0; k < run_len; k++) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
